// File: rtl/bin2bcd_pkg.sv
// Shared types for the streaming binary-to-BCD converter.
// dabble_adjust is the per-digit correction applied before every shift.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  function automatic bcd_digit_t dabble_adjust(bcd_digit_t d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/dabble_step.sv
// One combinational double-dabble step: adjust every digit, then shift in one magnitude bit.
// carry_out is the bit pushed out of the top digit, i.e. a sign that the value no longer fits.
module dabble_step
  import bin2bcd_pkg::*;
#(
  parameter int DIGIT_COUNT = 5
) (
  input  bcd_digit_t [DIGIT_COUNT-1:0] bcd_in,
  input  logic                         mag_msb,
  output bcd_digit_t [DIGIT_COUNT-1:0] bcd_out,
  output logic                         carry_out
);

  bcd_digit_t [DIGIT_COUNT-1:0] adj;

  always_comb begin
    adj = '0;
    for (int i = 0; i < DIGIT_COUNT; i++) begin
      adj[i] = dabble_adjust(bcd_in[i]);
    end
  end

  assign {carry_out, bcd_out} = {adj, mag_msb};

endmodule

// File: rtl/bin2bcd_stream.sv
// Streaming binary-to-BCD converter, BITS_PER_CYCLE double-dabble steps per clock,
// optional two's-complement input, saturating overflow and output backpressure.
//   state   | meaning
//   IDLE    | waiting for an input word
//   CONVERT | shifting magnitude bits into the BCD register
//   DONE    | result presented, waiting for out_ready
module bin2bcd_stream
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int DIGIT_COUNT    = 5,
  parameter int BITS_PER_CYCLE = 1,
  parameter int SIGNED         = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DIGIT_COUNT-1:0][3:0] out_digits,
  output logic                        out_sign,
  output logic                        out_overflow,
  output logic                        busy
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);

  if (WIDTH % BITS_PER_CYCLE != 0) begin : g_bpc_check
    $error("bin2bcd_stream: BITS_PER_CYCLE must divide WIDTH");
  end

  state_t                       state, state_next;
  bcd_digit_t [DIGIT_COUNT-1:0] bcd_q;
  logic [WIDTH-1:0]             mag_q;
  logic                         sign_q;
  logic                         ovf_q;
  logic [CW-1:0]                cnt_q;

  logic                         accept;
  logic                         last_step;
  logic                         sign_in;
  logic [WIDTH-1:0]             mag_in;
  logic                         ovf_next;
  logic [BITS_PER_CYCLE-1:0]    carry;
  bcd_digit_t [DIGIT_COUNT-1:0] chain [BITS_PER_CYCLE+1];

  assign accept    = in_valid && in_ready;
  assign last_step = (state == CONVERT) && (cnt_q == CW'(N - 1));
  assign sign_in   = (SIGNED != 0) ? in_data[WIDTH-1] : 1'b0;
  // Unsigned negate: the most negative input maps to 2**(WIDTH-1) without wrapping.
  assign mag_in    = sign_in ? (~in_data) + WIDTH'(1) : in_data;

  assign chain[0] = bcd_q;
  for (genvar s = 0; s < BITS_PER_CYCLE; s++) begin : g_step
    dabble_step #(.DIGIT_COUNT(DIGIT_COUNT)) u_step (
      .bcd_in    (chain[s]),
      .mag_msb   (mag_q[WIDTH-1-s]),
      .bcd_out   (chain[s+1]),
      .carry_out (carry[s])
    );
  end
  assign ovf_next = ovf_q | (|carry);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (in_valid)  state_next = CONVERT;
      CONVERT: if (last_step) state_next = DONE;
      DONE:    if (out_ready) state_next = in_valid ? CONVERT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      CONVERT: ;
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bcd_q  <= '0;
      mag_q  <= '0;
      sign_q <= 1'b0;
      ovf_q  <= 1'b0;
      cnt_q  <= '0;
    end else if (accept) begin
      bcd_q  <= '0;
      mag_q  <= mag_in;
      sign_q <= sign_in;
      ovf_q  <= 1'b0;
      cnt_q  <= '0;
    end else if (state == CONVERT) begin
      bcd_q  <= chain[BITS_PER_CYCLE];
      mag_q  <= mag_q << BITS_PER_CYCLE;
      ovf_q  <= ovf_next;
      cnt_q  <= cnt_q + CW'(1);
    end
  end

  // Output registers load only on the final step so they hold the last result otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_digits   <= '0;
      out_sign     <= 1'b0;
      out_overflow <= 1'b0;
    end else if (last_step) begin
      out_digits   <= ovf_next ? {DIGIT_COUNT{4'd9}} : chain[BITS_PER_CYCLE];
      out_sign     <= sign_q;
      out_overflow <= ovf_next;
    end
  end

endmodule

// File: tb/tb_bin2bcd_stream.sv
// Bench for bin2bcd_stream: three builds (unsigned 5-digit serial, 4-digit 4-bit/cycle,
// signed 5-digit 4-bit/cycle) checked every cycle against an arithmetic reference.
module tb_bin2bcd_stream;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [2:0]  iv, ir, ov, ordy, bsy, osg, oof;
  logic [15:0] id [3];
  logic [19:0] dg_a, dg_c;
  logic [15:0] dg_b;
  wire  [21:0] act [3];

  assign act[0] = {oof[0], osg[0], dg_a};
  assign act[1] = {oof[1], osg[1], 4'h0, dg_b};
  assign act[2] = {oof[2], osg[2], dg_c};

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;
  bit          pend [3];
  logic [21:0] expv [3];
  logic [21:0] last [3];
  int          due  [3];

  bin2bcd_stream #(.WIDTH(16), .DIGIT_COUNT(5), .BITS_PER_CYCLE(1), .SIGNED(0)) u_a (
    .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_digits(dg_a), .out_sign(osg[0]),
    .out_overflow(oof[0]), .busy(bsy[0]));

  bin2bcd_stream #(.WIDTH(16), .DIGIT_COUNT(4), .BITS_PER_CYCLE(4), .SIGNED(0)) u_b (
    .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_digits(dg_b), .out_sign(osg[1]),
    .out_overflow(oof[1]), .busy(bsy[1]));

  bin2bcd_stream #(.WIDTH(16), .DIGIT_COUNT(5), .BITS_PER_CYCLE(4), .SIGNED(1)) u_c (
    .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_digits(dg_c), .out_sign(osg[2]),
    .out_overflow(oof[2]), .busy(bsy[2]));

  function automatic int lat(int k);
    return (k == 0) ? 16 : 4;
  endfunction

  function automatic int ndig(int k);
    return (k == 1) ? 4 : 5;
  endfunction

  function automatic bit sgn(int k);
    return (k == 2);
  endfunction

  // Reference result {overflow, sign, digits[19:0]} by plain decimal arithmetic.
  function automatic logic [21:0] model(logic [15:0] v, bit signed_in, int nd);
    int unsigned m, lim;
    bit          s;
    logic [19:0] d;
    s   = signed_in && v[15];
    m   = s ? (32'd65536 - 32'(v)) : 32'(v);
    lim = 1;
    for (int i = 0; i < nd; i++) lim = lim * 10;
    d = '0;
    if (m >= lim) begin
      for (int i = 0; i < nd; i++) d[i*4 +: 4] = 4'd9;
      return {1'b1, s, d};
    end
    for (int i = 0; i < nd; i++) begin
      d[i*4 +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return {1'b0, s, d};
  endfunction

  task automatic chk(string name, logic [31:0] a, logic [31:0] e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, a, e, $time);
    end
  endtask

  // Scoreboard update: pop on handshake, push expected result on accept.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 3; k++) begin
      if (!reset) begin
        pend[k] = 1'b0;
        last[k] = '0;
      end else begin
        if (pend[k] && (cyc >= due[k]) && ordy[k]) begin
          last[k] = expv[k];
          pend[k] = 1'b0;
        end
        if (iv[k] && !pend[k]) begin
          expv[k] = model(id[k], sgn(k), ndig(k));
          pend[k] = 1'b1;
          due[k]  = cyc + lat(k) + 1;
        end
      end
    end
  end

  always @(negedge clk) begin : cmp_p
    bit ev;
    if (reset) begin
      for (int k = 0; k < 3; k++) begin
        ev = pend[k] && (cyc >= due[k]);
        chk($sformatf("d%0d_out_valid", k), 32'(ov[k]), 32'(ev));
        chk($sformatf("d%0d_%s", k, ev ? "result" : "hold"), 32'(act[k]), 32'(ev ? expv[k] : last[k]));
        chk($sformatf("d%0d_busy", k), 32'(bsy[k]), 32'(pend[k]));
        chk($sformatf("d%0d_in_ready", k), 32'(ir[k]), 32'(!pend[k] || (ev && ordy[k])));
      end
    end
  end

  task automatic send(int k, logic [15:0] v, output int waited);
    id[k] = v;
    iv[k] = 1'b1;
    waited = 0;
    @(posedge clk);
    while (!ir[k] && waited < 200) begin
      waited++;
      @(posedge clk);
    end
    chk($sformatf("d%0d_accept", k), 32'(ir[k]), 32'd1);
    #2;
    iv[k] = 1'b0;
  endtask

  task automatic wait_valid(int k, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ov[k] && n < 300);
  endtask

  task automatic wait_idle(int k);
    int n;
    n = 0;
    while (bsy[k] && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("d%0d_idle", k), 32'(bsy[k]), 32'd0);
  endtask

  task automatic run_lit(int k, logic [15:0] v, logic [19:0] e_dig, bit e_sgn, bit e_ovf);
    int w, n;
    send(k, v, w);
    wait_valid(k, n);
    chk($sformatf("d%0d_latency_%0d", k, v), 32'(n), 32'(lat(k) + 1));
    chk($sformatf("d%0d_digits_%0d", k, v), 32'(act[k][19:0]), 32'(e_dig));
    chk($sformatf("d%0d_sign_%0d", k, v), 32'(act[k][20]), 32'(e_sgn));
    chk($sformatf("d%0d_ovf_%0d", k, v), 32'(act[k][21]), 32'(e_ovf));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, n;
    logic [21:0] snap;
    reset = 1'b0;
    iv    = '0;
    ordy  = 3'b111;
    for (int k = 0; k < 3; k++) id[k] = '0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("d%0d_rst_out", k), 32'(act[k]), 32'd0);
      chk($sformatf("d%0d_rst_valid", k), 32'(ov[k]), 32'd0);
      chk($sformatf("d%0d_rst_busy", k), 32'(bsy[k]), 32'd0);
      chk($sformatf("d%0d_rst_in_ready", k), 32'(ir[k]), 32'd1);
    end
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;

    chk("model_ffff", 32'(model(16'hFFFF, 1'b0, 5)), 32'({2'b00, 20'h65535}));
    chk("model_12345_d4", 32'(model(16'd12345, 1'b0, 4)), 32'({2'b10, 20'h09999}));
    chk("model_8000_s", 32'(model(16'h8000, 1'b1, 5)), 32'({2'b01, 20'h32768}));
    chk("model_ffff_s", 32'(model(16'hFFFF, 1'b1, 5)), 32'({2'b01, 20'h00001}));

    run_lit(0, 16'hFFFF, 20'h65535, 1'b0, 1'b0);

    run_lit(1, 16'd12345, 20'h09999, 1'b0, 1'b1);
    run_lit(1, 16'd9999,  20'h09999, 1'b0, 1'b0);
    run_lit(1, 16'd10000, 20'h09999, 1'b0, 1'b1);

    run_lit(2, 16'h8000, 20'h32768, 1'b1, 1'b0);
    run_lit(2, 16'hFFFF, 20'h00001, 1'b1, 1'b0);
    run_lit(2, 16'h7FFF, 20'h32767, 1'b0, 1'b0);
    run_lit(2, 16'h0000, 20'h00000, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) wait_idle(k);

    fork
      begin
        int wb;
        for (int i = 0; i < 4000; i++)
          send(1, (i % 2 == 1) ? 16'($urandom_range(0, 12000)) : 16'($urandom), wb);
      end
      begin
        int wc;
        for (int j = 0; j < 4000; j++) send(2, 16'($urandom), wc);
      end
      begin
        int wa;
        for (int m = 0; m < 200; m++) send(0, 16'($urandom), wa);
      end
    join
    for (int k = 0; k < 3; k++) wait_idle(k);

    // Backpressure: result must sit still with in_ready low.
    ordy[0] = 1'b0;
    send(0, 16'd40960, w);
    wait_valid(0, n);
    snap = act[0];
    chk("bp_value", 32'(snap[19:0]), 32'h40960);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_stable", 32'(act[0]), 32'(snap));
      chk("bp_in_ready", 32'(ir[0]), 32'd0);
      chk("bp_valid", 32'(ov[0]), 32'd1);
    end
    @(posedge clk);
    #2;
    ordy[0] = 1'b1;
    send(0, 16'd555, w);
    chk("b2b_no_idle", 32'(w), 32'd0);
    @(negedge clk);
    chk("b2b_busy", 32'(bsy[0]), 32'd1);
    wait_valid(0, n);
    chk("b2b_result", 32'(act[0][19:0]), 32'h00555);
    wait_idle(0);

    // Reset in the middle of a conversion.
    send(0, 16'd50000, w);
    repeat (4) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_out", 32'(act[0]), 32'd0);
    chk("mid_rst_valid", 32'(ov[0]), 32'd0);
    chk("mid_rst_busy", 32'(bsy[0]), 32'd0);
    chk("mid_rst_in_ready", 32'(ir[0]), 32'd1);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b1;
    chk("post_rst_in_ready", 32'(ir[0]), 32'd1);
    run_lit(0, 16'd4321, 20'h04321, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) wait_idle(k);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
